// File: rtl/btb_pkg.sv
// Shared BTB definitions: prediction-state encodings, scheduler FSM states,
// the queued-update record and the 2-bit saturating prediction update.
package btb_pkg;

    localparam logic [1:0] ST_NT  = 2'b00;
    localparam logic [1:0] ST_WT  = 2'b01;
    localparam logic [1:0] ST_ST  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_DRAIN = 2'd1;
    localparam logic [1:0] FSM_FORCE = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  state;
    } btb_upd_t;

    // The reserved encoding is treated as a weak entry in either direction.
    function automatic logic [1:0] btb_next_state(input logic taken, input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            ST_NT:   nxt = taken ? ST_WT : ST_NT;
            ST_WT:   nxt = taken ? ST_ST : ST_NT;
            ST_ST:   nxt = taken ? ST_ST : ST_WT;
            ST_RSV:  nxt = taken ? ST_ST : ST_NT;
            default: nxt = ST_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small power-of-two FIFO holding pending BTB updates; the head is visible
// combinationally so it can be written in the same cycle it is popped.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses a push even when a pop frees a slot that cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/btb_update_sched.sv
// Shares the single BTB port between fetch lookups and queued execute-stage
// updates, forcing a write when an update has waited too long, and raises a
// one-cycle redirect for each accepted mispredicted branch.
module btb_update_sched
    import btb_pkg::*;
#(
    parameter int NUM_ENTRIES = 64,
    parameter int QDEPTH      = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lu_valid,
    input  logic [31:0] lu_pc,
    output logic        lu_ready,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [1:0]  ex_state,
    output logic        ex_ready,
    output logic        btb_rd,
    output logic [31:0] btb_rd_pc,
    output logic        btb_wr,
    output logic [31:0] btb_wr_pc,
    output logic [1:0]  btb_wr_state,
    output logic [31:0] btb_wr_target,
    output logic        flush,
    output logic [31:0] redirect_pc
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

    if (NUM_ENTRIES < 1 || STARVE_MAX < 1 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
        $error("btb_update_sched: unsupported NUM_ENTRIES/QDEPTH/STARVE_MAX");
    end

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          push, pop, full, empty, go_force, mispredict;
    logic [CW-1:0] count, count_next;
    btb_upd_t      push_upd, head_upd;

    assign ex_ready   = !full;
    assign push       = ex_valid && !full;
    assign mispredict = push && (ex_taken != ex_pred_taken);
    assign push_upd   = '{pc: ex_pc, target: ex_target, state: btb_next_state(ex_taken, ex_state)};
    assign count_next = count + CW'(push) - CW'(pop);

    btb_upd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(btb_upd_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_upd),
        .pop       (pop),
        .head      (head_upd),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Lookups win while draining; each lookup that starves the head ages it.
    always_comb begin
        lu_ready = 1'b1;
        pop      = 1'b0;
        wait_d   = wait_q;
        go_force = 1'b0;
        state_d  = FSM_IDLE;
        case (state_q)
            FSM_DRAIN: begin
                if (!lu_valid) begin
                    pop    = !empty;
                    wait_d = '0;
                end else begin
                    if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
                    go_force = (wait_d == WAIT_MAX) || full;
                end
            end
            FSM_FORCE: begin
                lu_ready = 1'b0;
                pop      = !empty;
                wait_d   = '0;
            end
            default: wait_d = '0;
        endcase
        if (go_force)                state_d = FSM_FORCE;
        else if (count_next != '0)   state_d = FSM_DRAIN;
    end

    assign btb_rd        = lu_valid && lu_ready;
    assign btb_rd_pc     = lu_pc;
    assign btb_wr        = pop;
    assign btb_wr_pc     = head_upd.pc;
    assign btb_wr_state  = head_upd.state;
    assign btb_wr_target = head_upd.target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FSM_IDLE;
            wait_q      <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flush   <= mispredict;
            if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_btb_update_sched.sv
// Bench for btb_update_sched: directed vector table for the corner cases,
// then randomized traffic checked against a queue-based reference model.
module tb_btb_update_sched;
    localparam int QDEPTH     = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        lu_valid, lu_ready;
    logic [31:0] lu_pc;
    logic        ex_valid, ex_taken, ex_pred_taken, ex_ready;
    logic [31:0] ex_pc, ex_target;
    logic [1:0]  ex_state;
    logic        btb_rd, btb_wr, flush;
    logic [31:0] btb_rd_pc, btb_wr_pc, btb_wr_target, redirect_pc;
    logic [1:0]  btb_wr_state;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    btb_update_sched #(
        .NUM_ENTRIES (64),
        .QDEPTH      (QDEPTH),
        .STARVE_MAX  (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lu_valid      (lu_valid),
        .lu_pc         (lu_pc),
        .lu_ready      (lu_ready),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_state      (ex_state),
        .ex_ready      (ex_ready),
        .btb_rd        (btb_rd),
        .btb_rd_pc     (btb_rd_pc),
        .btb_wr        (btb_wr),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_state  (btb_wr_state),
        .btb_wr_target (btb_wr_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
    );

    typedef struct {
        logic rst, lv; logic [31:0] lpc;
        logic ev; logic [31:0] epc, etgt; logic tk, pr; logic [1:0] st;
        logic e_lu, e_exr, e_rd, e_wr; logic [31:0] e_wpc; logic [1:0] e_wst; logic [31:0] e_wtgt;
        logic e_fl; logic [31:0] e_redir;
    } vec_t;
    vec_t vecs[$];

    typedef struct { logic [31:0] pc, target; logic [1:0] st; } upd_t;
    upd_t        mq[$];
    int          starve;
    bit          force_m, flush_m;
    logic [31:0] redir_m;

    task automatic addVec(input logic r, input logic lv, input logic [31:0] lpc,
                          input logic ev, input logic [31:0] epc, input logic [31:0] etgt,
                          input logic tk, input logic pr, input logic [1:0] st,
                          input logic elu, input logic eexr, input logic erd, input logic ewr,
                          input logic [31:0] ewpc, input logic [1:0] ewst, input logic [31:0] ewtgt,
                          input logic efl, input logic [31:0] eredir);
        vec_t v;
        v = '{r, lv, lpc, ev, epc, etgt, tk, pr, st, elu, eexr, erd, ewr, ewpc, ewst, ewtgt, efl, eredir};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [31:0] lpc,
                                 input logic ev, input logic [31:0] epc, input logic [31:0] etgt,
                                 input logic tk, input logic pr, input logic [1:0] st);
        rst = r; lu_valid = lv; lu_pc = lpc; ex_valid = ev; ex_pc = epc;
        ex_target = etgt; ex_taken = tk; ex_pred_taken = pr; ex_state = st;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Prediction update straight from the state table.
    function automatic logic [1:0] specNext(input logic taken, input logic [1:0] st);
        if (taken) return (st == 2'b00) ? 2'b01 : 2'b10;
        return (st == 2'b10) ? 2'b01 : 2'b00;
    endfunction

    task automatic modelReset();
        mq.delete();
        starve  = 0;
        force_m = 1'b0;
        flush_m = 1'b0;
        redir_m = '0;
    endtask

    initial begin
        vec_t v;
        logic r, lv, ev, tk, pr, e_lu, e_wr, e_exr, acc;
        logic [31:0] lpc, epc, etgt;
        logic [1:0] st;
        upd_t u;

        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset flush", flush, 0);
        checkOutput("reset redirect_pc", redirect_pc, 0);
        checkOutput("reset btb_wr", btb_wr, 0);
        checkOutput("reset lu_ready", lu_ready, 1);
        checkOutput("reset ex_ready", ex_ready, 1);
        @(posedge clk);
        #1;

        // rst lv lpc | ev epc etgt tk pr st | lu exr rd wr wpc wst wtgt | fl redir
        addVec(0,1,'h100, 0,0,0,0,0,2'b00,          1,1,1,0, 0,0,0, 0,0);
        addVec(0,0,0, 1,'h40,'h80,1,1,2'b01,         1,1,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,1, 'h40,2'b10,'h80, 0,0);
        addVec(0,1,'h104, 1,'h44,'h90,0,0,2'b10,     1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h108, 0,0,0,0,0,2'b00,           1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h10C, 0,0,0,0,0,2'b00,           1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h110, 0,0,0,0,0,2'b00,           1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h114, 0,0,0,0,0,2'b00,           0,1,0,1, 'h44,2'b01,'h90, 0,0);
        addVec(0,1,'h120, 1,'h300,'h400,1,1,2'b00,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h124, 1,'h304,'h404,1,1,2'b01,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h128, 1,'h308,'h408,1,1,2'b10,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h12C, 1,'h30C,'h40C,1,1,2'b11,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h130, 1,'h310,'h410,1,0,2'b00,   0,0,0,1, 'h300,2'b01,'h400, 0,0);
        addVec(0,1,'h134, 1,'h314,'h414,0,0,2'b01,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h138, 0,0,0,0,0,2'b00,           1,0,1,0, 0,0,0, 0,0);
        addVec(0,1,'h13C, 0,0,0,0,0,2'b00,           0,0,0,1, 'h304,2'b10,'h404, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,1, 'h308,2'b10,'h408, 0,0);
        addVec(0,1,'h140, 1,'h318,'h418,1,1,2'b00,   1,1,1,0, 0,0,0, 0,0);
        addVec(1,0,0, 0,0,0,0,0,2'b00,               0,0,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 1,'h200,'h500,0,1,2'b10,       1,1,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,1, 'h200,2'b01,'h500, 1,'h204);
        addVec(0,0,0, 1,'hFFFFFFFC,'h600,0,1,2'b01,  1,1,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,1, 'hFFFFFFFC,2'b00,'h600, 1,'h0);
        addVec(0,1,'h150, 1,'h700,'h900,1,0,2'b00,   1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h154, 1,'h800,'hA00,0,1,2'b11,   1,1,1,0, 0,0,0, 1,'h900);
        addVec(0,1,'h158, 0,0,0,0,0,2'b00,           1,1,1,0, 0,0,0, 1,'h804);
        addVec(0,1,'h15C, 0,0,0,0,0,2'b00,           1,1,1,0, 0,0,0, 0,0);
        addVec(0,1,'h160, 0,0,0,0,0,2'b00,           0,1,0,1, 'h700,2'b01,'h900, 0,0);
        addVec(0,1,'h164, 1,'h1000,'h2000,1,0,2'b00, 1,1,1,0, 0,0,0, 0,0);
        addVec(1,0,0, 0,0,0,0,0,2'b00,               0,0,0,0, 0,0,0, 0,0);
        addVec(0,0,0, 0,0,0,0,0,2'b00,               1,1,0,0, 0,0,0, 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.rst, v.lv, v.lpc, v.ev, v.epc, v.etgt, v.tk, v.pr, v.st);
            @(negedge clk);
            if (!v.rst) begin
                checkOutput($sformatf("vec%0d lu_ready", i), lu_ready, v.e_lu);
                checkOutput($sformatf("vec%0d ex_ready", i), ex_ready, v.e_exr);
                checkOutput($sformatf("vec%0d btb_rd", i), btb_rd, v.e_rd);
                checkOutput($sformatf("vec%0d btb_wr", i), btb_wr, v.e_wr);
                checkOutput($sformatf("vec%0d flush", i), flush, v.e_fl);
                if (v.e_rd) checkOutput($sformatf("vec%0d btb_rd_pc", i), btb_rd_pc, v.lpc);
                if (v.e_wr) begin
                    checkOutput($sformatf("vec%0d btb_wr_pc", i), btb_wr_pc, v.e_wpc);
                    checkOutput($sformatf("vec%0d btb_wr_state", i), btb_wr_state, v.e_wst);
                    checkOutput($sformatf("vec%0d btb_wr_target", i), btb_wr_target, v.e_wtgt);
                end
                if (v.e_fl) checkOutput($sformatf("vec%0d redirect_pc", i), redirect_pc, v.e_redir);
            end
            @(posedge clk);
            #1;
        end

        // Random traffic against the reference model, starting from a clean reset.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            r    = ($urandom_range(0, 299) == 0);
            lv   = ($urandom_range(0, 9) < 6);
            lpc  = $urandom;
            ev   = ($urandom_range(0, 9) < 5);
            epc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
            etgt = $urandom;
            tk   = $urandom_range(0, 1);
            pr   = $urandom_range(0, 1);
            st   = 2'($urandom_range(0, 3));
            applyStimulus(r, lv, lpc, ev, epc, etgt, tk, pr, st);
            @(negedge clk);
            if (r) begin
                modelReset();
            end else begin
                e_exr = (mq.size() < QDEPTH);
                e_lu  = !force_m;
                e_wr  = force_m || (mq.size() > 0 && !lv);
                checkOutput($sformatf("rnd%0d lu_ready", c), lu_ready, e_lu);
                checkOutput($sformatf("rnd%0d ex_ready", c), ex_ready, e_exr);
                checkOutput($sformatf("rnd%0d btb_rd", c), btb_rd, lv && e_lu);
                checkOutput($sformatf("rnd%0d btb_rd_pc", c), btb_rd_pc, lpc);
                checkOutput($sformatf("rnd%0d btb_wr", c), btb_wr, e_wr);
                if (e_wr) begin
                    checkOutput($sformatf("rnd%0d btb_wr_pc", c), btb_wr_pc, mq[0].pc);
                    checkOutput($sformatf("rnd%0d btb_wr_state", c), btb_wr_state, mq[0].st);
                    checkOutput($sformatf("rnd%0d btb_wr_target", c), btb_wr_target, mq[0].target);
                end
                checkOutput($sformatf("rnd%0d flush", c), flush, flush_m);
                if (flush_m) checkOutput($sformatf("rnd%0d redirect_pc", c), redirect_pc, redir_m);

                acc = ev && e_exr;
                if (force_m) begin
                    force_m = 1'b0;
                    starve  = 0;
                end else if (mq.size() > 0 && lv) begin
                    if (starve < STARVE_MAX) starve++;
                    force_m = (starve == STARVE_MAX) || (mq.size() == QDEPTH);
                end else begin
                    starve = 0;
                end
                if (e_wr) void'(mq.pop_front());
                if (acc) begin
                    u = '{pc: epc, target: etgt, st: specNext(tk, st)};
                    mq.push_back(u);
                end
                flush_m = acc && (tk != pr);
                if (flush_m) redir_m = tk ? etgt : epc + 32'd4;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/btb_update_sched.md
BTB_UPDATE_SCHED -- requirements
Module: btb_update_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, meaning number of BTB entries served.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning update-queue depth (power of two).
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning maximum cycles a queued update waits behind lookups.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  synchronous active-high reset.
REQ-006 SHALL have lu_valid  in  1  fetch lookup request.
REQ-007 SHALL have lu_pc  in  32  fetch lookup PC.
REQ-008 SHALL have lu_ready  out  1  lookup granted this cycle.
REQ-009 SHALL have ex_valid  in  1  resolved branch from execute.
REQ-010 SHALL have ex_pc, ex_target  in  32 each  branch PC and resolved target.
REQ-011 SHALL have ex_taken, ex_pred_taken  in  1 each  actual and predicted outcome.
REQ-012 SHALL have ex_state  in  2  prediction state used at fetch.
REQ-013 SHALL have ex_ready  out  1  resolved branch accepted.
REQ-014 SHALL have btb_rd  out  1 and btb_rd_pc  out  32  BTB lookup strobe and PC.
REQ-015 SHALL have btb_wr  out  1, btb_wr_pc  out  32, btb_wr_state  out  2, btb_wr_target  out  32  BTB write port.
REQ-016 SHALL have flush  out  1 and redirect_pc  out  32  mispredict redirect.

Function
REQ-017 SHALL arbitrate one BTB port per cycle: a lookup (btb_rd) or a write (btb_wr), never both.
REQ-018 SHALL assert ex_ready = !full; a resolved branch is accepted when ex_valid && ex_ready.
REQ-019 SHALL push accepted branches into a FIFO of {pc, target, new_state}; with simultaneous push and pop the count is unchanged; full blocks push even if a pop occurs that cycle.
REQ-020 SHALL compute new_state at push: taken: 00->01, 01->10, 10->10, 11->10; not taken: 10->01, 01->00, 00->00, 11->00.
REQ-021 SHALL run FSM IDLE (queue empty), DRAIN (queue non-empty, lookups have priority), FORCE (head write forced).
REQ-022 SHALL in IDLE grant lookups (lu_ready=1); go to DRAIN on first push.
REQ-023 SHALL in DRAIN write the head when lu_valid=0, else grant the lookup and increment wait_cnt; go to FORCE when wait_cnt reaches STARVE_MAX or the queue is full with lu_valid=1.
REQ-024 SHALL in FORCE drive lu_ready=0, write the head, clear wait_cnt, return to DRAIN (queue still non-empty) or IDLE (empty).
REQ-025 SHALL clear wait_cnt on every head pop; wait_cnt saturates at STARVE_MAX.
REQ-026 SHALL drive btb_rd = lu_valid && lu_ready and btb_rd_pc = lu_pc combinationally, zero-latency.
REQ-027 SHALL drive btb_wr/btb_wr_* from FIFO head combinationally in the pop cycle.
REQ-028 SHALL on accepted branch with ex_taken != ex_pred_taken assert flush for exactly one cycle, one cycle after acceptance, with redirect_pc = ex_taken ? ex_target : ex_pc + 4 (32-bit wrap).
REQ-029 SHALL still enqueue mispredicted branches; flush does not clear the queue.
REQ-030 SHALL on back-to-back mispredicts pulse flush in each following cycle with the corresponding redirect_pc.

Reset
REQ-031 SHALL on rst clear FIFO pointers and count, wait_cnt, go to IDLE, drive flush=0, redirect_pc=0, btb_wr=0; lu_ready=1, ex_ready=1 after reset.
REQ-032 SHALL discard queued updates and any pending flush when rst asserts mid-operation.

Structure
REQ-033 SHALL place the state encodings (NT=00, WT=01, ST=10, RSV=11), FSM state encoding and the saturating update function in a shared package btb_pkg.
REQ-034 SHALL implement the queue as sub-module btb_upd_fifo (parameterised depth/width, full/empty, push/pop).

Verification
REQ-035 SHALL cover: reset, lu_valid=1 lu_pc=0x100 -> btb_rd=1 btb_rd_pc=0x100 same cycle, btb_wr=0.
REQ-036 SHALL cover: ex push pc=0x40 taken=1 state=01 target=0x80, lu_valid=0 -> next cycle btb_wr=1 pc=0x40 state=10 target=0x80.
REQ-037 SHALL cover: one queued update, lu_valid held 1 -> lookups granted 3 cycles, 4th cycle lu_ready=0 and btb_wr=1.
REQ-038 SHALL cover: 4 pushes with lu_valid=1 -> ex_ready=0 after 4th, FORCE entered, ex_ready=1 after the pop.
REQ-039 SHALL cover: pc=0x200 pred=1 taken=0 -> flush=1 one cycle later, redirect_pc=0x204; pc=0xFFFFFFFC same case -> redirect_pc=0x0.
REQ-040 SHALL cover: rst asserted with 3 entries queued -> next cycle btb_wr=0, ex_ready=1, no writes until new pushes.
